// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: instruction container, memory-op kind and FSM state.
package mem_access_stage_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NONE = 2'd0,
      MEM_OP_LW   = 2'd1,
      MEM_OP_SW   = 2'd2
   } mem_op_e;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      mem_op_e     memOp;
      logic        regWrite;
   } instr_structure;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;

   function automatic logic isWordAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Ready-handshaked data-memory port between the MEM stage (master) and data memory (slave).
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ready, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, rdata
   );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register; wb_valid and wb_fault are single-cycle pulses per load.
module mem_wb_reg
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              inFault,
   input  instr_structure    inICont,
   input  logic [DATA_W-1:0] inResult,
   input  logic [DATA_W-1:0] inLData,
   output logic              outValid,
   output logic              outFault,
   output instr_structure    outICont,
   output logic [DATA_W-1:0] outResult,
   output logic [DATA_W-1:0] outLData
);

   // Payload holds between loads; the valid/fault flags fall back to 0 every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outValid  <= 1'b0;
         outFault  <= 1'b0;
         outICont  <= '0;
         outResult <= '0;
         outLData  <= '0;
      end else begin
         outValid <= load;
         outFault <= load && inFault;
         if (load) begin
            outICont  <= inICont;
            outResult <= inResult;
            outLData  <= inLData;
         end
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the MIPS core: LW/SW over a ready handshake, stalls EX while an access is open.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_valid,
   input  instr_structure      ex_iCont,
   input  logic [DATA_W-1:0]   ex_alu_result,
   input  logic [DATA_W-1:0]   ex_store_data,
   output logic                mem_stall,
   mem_access_stage_if.master  dmem,
   output logic                wb_valid,
   output instr_structure      wb_iCont,
   output logic [DATA_W-1:0]   result_fromALU,
   output logic [DATA_W-1:0]   lData,
   output logic                wb_fault
);

   mem_state_e        state;
   mem_state_e        nextState;
   instr_structure    latchICont;
   logic [DATA_W-1:0] latchResult;
   logic [DATA_W-1:0] latchData;
   logic [ADDR_W-1:0] latchAddr;
   logic              accept;
   logic              isMemOp;
   logic              aligned;
   logic              timeoutHit;
   logic              dmemReq;
   logic              wbLoad;
   logic              wbFaultIn;
   instr_structure    wbICont;
   logic [DATA_W-1:0] wbResult;
   logic [DATA_W-1:0] wbLData;

   assign mem_stall = (state == ACCESS);
   assign accept    = ex_valid && !mem_stall;
   assign isMemOp   = (ex_iCont.memOp != MEM_OP_NONE);
   assign aligned   = isWordAligned(ex_alu_result[1:0]);
   assign latchAddr = {latchResult[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Capture the request on an aligned LW/SW accept so the bus stays stable while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latchICont  <= '0;
         latchResult <= '0;
         latchData   <= '0;
      end else if (accept && isMemOp && aligned) begin
         latchICont  <= ex_iCont;
         latchResult <= ex_alu_result;
         latchData   <= ex_store_data;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] waitCnt;

   // The final wait cycle is the timeout cycle itself, so dmem_req stays high exactly TIMEOUT_CYCLES cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waitCnt <= '0;
      end else if (state != ACCESS) begin
         waitCnt <= '0;
      end else if (!dmem.ready) begin
         waitCnt <= waitCnt + 1'b1;
      end
   end

   assign timeoutHit = (state == ACCESS) && !dmem.ready &&
                       (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeoutHit = 1'b0;
`endif

   // Next state plus what to load into MEM/WB; ready beats a same-cycle timeout.
   always_comb begin
      nextState = state;
      dmemReq   = 1'b0;
      wbLoad    = 1'b0;
      wbFaultIn = 1'b0;
      wbICont   = ex_iCont;
      wbResult  = ex_alu_result;
      wbLData   = '0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!isMemOp) begin
                  wbLoad = 1'b1;
               end else if (!aligned) begin
                  wbLoad    = 1'b1;
                  wbFaultIn = 1'b1;
               end else begin
                  nextState = ACCESS;
               end
            end
         end
         ACCESS: begin
            dmemReq  = 1'b1;
            wbICont  = latchICont;
            wbResult = latchResult;
            if (dmem.ready) begin
               wbLoad    = 1'b1;
               nextState = IDLE;
               if (latchICont.memOp == MEM_OP_LW) begin
                  wbLData = dmem.rdata;
               end
            end else if (timeoutHit) begin
               wbLoad    = 1'b1;
               wbFaultIn = 1'b1;
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign dmem.req   = dmemReq;
   assign dmem.we    = dmemReq && (latchICont.memOp == MEM_OP_SW);
   assign dmem.addr  = dmemReq ? latchAddr : '0;
   assign dmem.wdata = dmemReq ? latchData : '0;

   mem_wb_reg #(
      .DATA_W(DATA_W)
   ) memWbReg (
      .clk      (clk),
      .rst      (rst),
      .load     (wbLoad),
      .inFault  (wbFaultIn),
      .inICont  (wbICont),
      .inResult (wbResult),
      .inLData  (wbLData),
      .outValid (wb_valid),
      .outFault (wb_fault),
      .outICont (wb_iCont),
      .outResult(result_fromALU),
      .outLData (lData)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   logic           clk;
   logic           rst;
   logic           ex_valid;
   instr_structure ex_iCont;
   logic [31:0]    ex_alu_result;
   logic [31:0]    ex_store_data;
   logic           mem_stall;
   logic           wb_valid;
   instr_structure wb_iCont;
   logic [31:0]    result_fromALU;
   logic [31:0]    lData;
   logic           wb_fault;
   int             total;
   int             bad;

   mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) dmemBus ();

   mem_access_stage #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef MEM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(4)
`endif
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_iCont      (ex_iCont),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .mem_stall     (mem_stall),
      .dmem          (dmemBus.master),
      .wb_valid      (wb_valid),
      .wb_iCont      (wb_iCont),
      .result_fromALU(result_fromALU),
      .lData         (lData),
      .wb_fault      (wb_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic instr_structure mkInstr(input mem_op_e op);
      instr_structure i;
      i          = '0;
      i.memOp    = op;
      i.opcode   = (op == MEM_OP_LW) ? 6'h23 : ((op == MEM_OP_SW) ? 6'h2B : 6'h00);
      i.rt       = 5'd9;
      i.regWrite = (op != MEM_OP_SW);
      return i;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input mem_op_e op, input logic [31:0] alu,
                                input logic [31:0] st);
      ex_valid      = v;
      ex_iCont      = mkInstr(op);
      ex_alu_result = alu;
      ex_store_data = st;
   endtask

   task automatic test_reset;
      tick;
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset mem_stall got=%b exp=0", mem_stall); end
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL reset req got=%b exp=0", dmemBus.req); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset wb_valid got=%b exp=0", wb_valid); end
      total++; if (wb_fault !== 1'b0) begin bad++; $display("[TB] FAIL reset wb_fault got=%b exp=0", wb_fault); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL reset lData got=%h exp=0", lData); end
      total++; if (result_fromALU !== 32'h0) begin bad++; $display("[TB] FAIL reset result got=%h exp=0", result_fromALU); end
      total++; if (wb_iCont !== instr_structure'('0)) begin bad++; $display("[TB] FAIL reset wb_iCont got=%h exp=0", wb_iCont); end
      rst = 1'b0;
      tick;
      // Reset in the middle of an LW access must drop the request asynchronously.
      applyStimulus(1'b1, MEM_OP_LW, 32'h100, 32'h0);
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      total++; if (dmemBus.req !== 1'b1) begin bad++; $display("[TB] FAIL rstAccess req got=%b exp=1", dmemBus.req); end
      total++; if (dmemBus.addr !== 32'h100) begin bad++; $display("[TB] FAIL rstAccess addr got=%h exp=100", dmemBus.addr); end
      rst = 1'b1;
      #1;
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL rstAsync req got=%b exp=0", dmemBus.req); end
      total++; if (dmemBus.addr !== 32'h0) begin bad++; $display("[TB] FAIL rstAsync addr got=%h exp=0", dmemBus.addr); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstAsync wb_valid got=%b exp=0", wb_valid); end
      tick;
      rst = 1'b0;
      tick;
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL rstRelease mem_stall got=%b exp=0", mem_stall); end
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL rstRelease req got=%b exp=0", dmemBus.req); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstRelease wb_valid got=%b exp=0", wb_valid); end
   endtask

   task automatic test_add;
      dmemBus.ready = 1'b1;
      applyStimulus(1'b1, MEM_OP_NONE, 32'h0000_0007, 32'h0);
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL add stallBefore got=%b exp=0", mem_stall); end
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL add wb_valid got=%b exp=1", wb_valid); end
      total++; if (result_fromALU !== 32'h7) begin bad++; $display("[TB] FAIL add result got=%h exp=7", result_fromALU); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL add lData got=%h exp=0", lData); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL add stallAfter got=%b exp=0", mem_stall); end
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL add idleReady req got=%b exp=0", dmemBus.req); end
      tick;
      dmemBus.ready = 1'b0;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL add pulse got=%b exp=0", wb_valid); end
   endtask

   task automatic test_lw_zero_wait;
      applyStimulus(1'b1, MEM_OP_LW, 32'h40, 32'h0);
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      total++; if (dmemBus.req !== 1'b1) begin bad++; $display("[TB] FAIL lw reqT1 got=%b exp=1", dmemBus.req); end
      total++; if (dmemBus.we !== 1'b0) begin bad++; $display("[TB] FAIL lw we got=%b exp=0", dmemBus.we); end
      total++; if (dmemBus.addr !== 32'h40) begin bad++; $display("[TB] FAIL lw addr got=%h exp=40", dmemBus.addr); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL lw validT1 got=%b exp=0", wb_valid); end
      dmemBus.ready = 1'b1;
      dmemBus.rdata = 32'hCAFE_F00D;
      tick;
      dmemBus.ready = 1'b0;
      dmemBus.rdata = 32'h0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL lw validT2 got=%b exp=1", wb_valid); end
      total++; if (lData !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL lw lData got=%h exp=cafef00d", lData); end
      total++; if (result_fromALU !== 32'h40) begin bad++; $display("[TB] FAIL lw result got=%h exp=40", result_fromALU); end
      total++; if (wb_iCont !== mkInstr(MEM_OP_LW)) begin bad++; $display("[TB] FAIL lw iCont got=%h exp=%h", wb_iCont, mkInstr(MEM_OP_LW)); end
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL lw reqT2 got=%b exp=0", dmemBus.req); end
      total++; if (dmemBus.addr !== 32'h0) begin bad++; $display("[TB] FAIL lw addrIdle got=%h exp=0", dmemBus.addr); end
      total++; if (wb_fault !== 1'b0) begin bad++; $display("[TB] FAIL lw fault got=%b exp=0", wb_fault); end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      applyStimulus(1'b1, MEM_OP_LW, 32'h100, 32'h0);
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         total++; if (dmemBus.req !== 1'b1) begin bad++; $display("[TB] FAIL timeout req[%0d] got=%b exp=1", i, dmemBus.req); end
         tick;
      end
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL timeout reqDrop got=%b exp=0", dmemBus.req); end
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL timeout wb_valid got=%b exp=1", wb_valid); end
      total++; if (wb_fault !== 1'b1) begin bad++; $display("[TB] FAIL timeout wb_fault got=%b exp=1", wb_fault); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL timeout lData got=%h exp=0", lData); end
      tick;
      total++; if (wb_fault !== 1'b0) begin bad++; $display("[TB] FAIL timeout faultPulse got=%b exp=0", wb_fault); end
   endtask
`else
   task automatic test_no_timeout;
      applyStimulus(1'b1, MEM_OP_LW, 32'h100, 32'h0);
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      for (int i = 0; i < 20; i++) begin
         total++; if (dmemBus.req !== 1'b1) begin bad++; $display("[TB] FAIL noTimeout req[%0d] got=%b exp=1", i, dmemBus.req); end
         tick;
      end
      dmemBus.ready = 1'b1;
      dmemBus.rdata = 32'h0000_55AA;
      tick;
      dmemBus.ready = 1'b0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL noTimeout wb_valid got=%b exp=1", wb_valid); end
      total++; if (wb_fault !== 1'b0) begin bad++; $display("[TB] FAIL noTimeout wb_fault got=%b exp=0", wb_fault); end
      total++; if (lData !== 32'h0000_55AA) begin bad++; $display("[TB] FAIL noTimeout lData got=%h exp=55aa", lData); end
   endtask
`endif

   task automatic test_sw_waits;
      int pulses;
      pulses = 0;
      applyStimulus(1'b1, MEM_OP_SW, 32'h44, 32'h1234_5678);
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         total++; if (dmemBus.req !== 1'b1) begin bad++; $display("[TB] FAIL sw req[%0d] got=%b exp=1", i, dmemBus.req); end
         total++; if (dmemBus.we !== 1'b1) begin bad++; $display("[TB] FAIL sw we[%0d] got=%b exp=1", i, dmemBus.we); end
         total++; if (dmemBus.addr !== 32'h44) begin bad++; $display("[TB] FAIL sw addr[%0d] got=%h exp=44", i, dmemBus.addr); end
         total++; if (dmemBus.wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL sw wdata[%0d] got=%h exp=12345678", i, dmemBus.wdata); end
         total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL sw stall[%0d] got=%b exp=1", i, mem_stall); end
         if (wb_valid) pulses++;
         dmemBus.ready = (i == 3);
         tick;
      end
      dmemBus.ready = 1'b0;
      if (wb_valid) pulses++;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL sw wb_valid got=%b exp=1", wb_valid); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL sw lData got=%h exp=0", lData); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL sw stallExit got=%b exp=0", mem_stall); end
      tick;
      if (wb_valid) pulses++;
      total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL sw pulses got=%0d exp=1", pulses); end
   endtask

   task automatic test_misaligned;
      applyStimulus(1'b1, MEM_OP_LW, 32'h42, 32'h0);
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL misaligned reqAccept got=%b exp=0", dmemBus.req); end
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      total++; if (dmemBus.req !== 1'b0) begin bad++; $display("[TB] FAIL misaligned req got=%b exp=0", dmemBus.req); end
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL misaligned wb_valid got=%b exp=1", wb_valid); end
      total++; if (wb_fault !== 1'b1) begin bad++; $display("[TB] FAIL misaligned wb_fault got=%b exp=1", wb_fault); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL misaligned lData got=%h exp=0", lData); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL misaligned stall got=%b exp=0", mem_stall); end
      tick;
      total++; if (wb_fault !== 1'b0) begin bad++; $display("[TB] FAIL misaligned faultPulse got=%b exp=0", wb_fault); end
   endtask

   task automatic test_back_to_back;
      applyStimulus(1'b1, MEM_OP_LW, 32'h80, 32'h0);
      tick;
      // EX now presents an ADD that must wait until the LW has left ACCESS.
      applyStimulus(1'b1, MEM_OP_NONE, 32'h9, 32'h0);
      dmemBus.ready = 1'b1;
      dmemBus.rdata = 32'hA5A5_0001;
      total++; if (mem_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b stall got=%b exp=1", mem_stall); end
      tick;
      dmemBus.ready = 1'b0;
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b lwValid got=%b exp=1", wb_valid); end
      total++; if (lData !== 32'hA5A5_0001) begin bad++; $display("[TB] FAIL b2b lwData got=%h exp=a5a50001", lData); end
      total++; if (result_fromALU !== 32'h80) begin bad++; $display("[TB] FAIL b2b lwResult got=%h exp=80", result_fromALU); end
      total++; if (mem_stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b stallExit got=%b exp=0", mem_stall); end
      tick;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      total++; if (wb_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b addValid got=%b exp=1", wb_valid); end
      total++; if (result_fromALU !== 32'h9) begin bad++; $display("[TB] FAIL b2b addResult got=%h exp=9", result_fromALU); end
      total++; if (lData !== 32'h0) begin bad++; $display("[TB] FAIL b2b addLData got=%h exp=0", lData); end
      tick;
      total++; if (wb_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b idle got=%b exp=0", wb_valid); end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b1;
      dmemBus.ready = 1'b0;
      dmemBus.rdata = 32'h0;
      applyStimulus(1'b0, MEM_OP_NONE, 32'h0, 32'h0);
      test_reset;
      test_add;
      test_lw_zero_wait;
`ifdef MEM_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      test_sw_waits;
      test_misaligned;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
